// File: rtl/gm_pkg.sv
// Shared constants, state/class encodings and the 3x3 neighbour table
// for the gradient-magnitude double-threshold stage.
package gm_pkg;

  localparam int DATA_W = 24;
  localparam int WIN    = 3;
  localparam int N      = WIN * WIN;
  localparam int IDX_W  = 4;

  localparam logic [DATA_W-1:0] EDGE_VAL = DATA_W'(255);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLASSIFY = 2'd1,
    HYST     = 2'd2,
    DONE     = 2'd3
  } state_t;

  typedef logic [1:0] cls_t;

  localparam cls_t CLS_NONE   = 2'b00;
  localparam cls_t CLS_WEAK   = 2'b01;
  localparam cls_t CLS_STRONG = 2'b10;

  // bit k set when element k is 8-adjacent to the indexing element
  localparam logic [N-1:0] NBR_MASK [N] = '{
    9'h01A, 9'h03D, 9'h032,
    9'h0D3, 9'h1EF, 9'h196,
    9'h098, 9'h178, 9'h0B0
  };

endpackage

// File: rtl/gm_double_threshold_if.sv
// Enable/done handshake plus window and threshold buses.
// master drives window/thresholds/Enable; slave returns img_result/done.
interface gm_double_threshold_if;
  import gm_pkg::*;

  logic                  Enable;
  logic [N*DATA_W-1:0]   GM_T;
  logic [DATA_W-1:0]     high_thr;
  logic [DATA_W-1:0]     low_thr;
  logic [N*DATA_W-1:0]   img_result;
  logic                  done;

  modport master (
    output Enable, GM_T, high_thr, low_thr,
    input  img_result, done
  );

  modport slave (
    input  Enable, GM_T, high_thr, low_thr,
    output img_result, done
  );

endinterface

// File: rtl/gm_thr_classify.sv
// Combinational strong/weak/none classifier for one element.
// Ports: g, high_thr, low_thr in; cls out (gm_pkg class code).
module gm_thr_classify
  import gm_pkg::*;
(
  input  logic [DATA_W-1:0] g,
  input  logic [DATA_W-1:0] high_thr,
  input  logic [DATA_W-1:0] low_thr,
  output cls_t              cls
);

  // strong is tested first, so an inverted low/high pair never
  // yields a weak element
  always_comb begin
    cls = CLS_NONE;
    if (g >= high_thr)
      cls = CLS_STRONG;
    else if (g >= low_thr)
      cls = CLS_WEAK;
  end

endmodule

// File: rtl/gm_double_threshold.sv
// Double threshold + hysteresis over one 3x3 GM window.
// Ports: Clock, reset (sync, active-high), bus (slave handshake).
module gm_double_threshold
  import gm_pkg::*;
(
  input  logic                 Clock,
  input  logic                 reset,
  gm_double_threshold_if.slave bus
);

  state_t             state;
  state_t             state_n;
  logic [IDX_W-1:0]   idx;
  cls_t               cls_q [N];
  logic [DATA_W-1:0]  gm_q [N];
  logic [DATA_W-1:0]  hi_q;
  logic [DATA_W-1:0]  lo_q;
  logic [N*DATA_W-1:0] img_q;
  logic               done_q;

  cls_t               cls_cur;
  logic [N-1:0]       strong_vec;
  logic               nbr_hit;
  logic [DATA_W-1:0]  elem_val;
  logic               last;

  assign bus.img_result = img_q;
  assign bus.done       = done_q;
  assign last           = (idx == IDX_W'(N - 1));

  gm_thr_classify u_cls (
    .g        (gm_q[idx]),
    .high_thr (hi_q),
    .low_thr  (lo_q),
    .cls      (cls_cur)
  );

  always_comb begin
    strong_vec = '0;
    for (int k = 0; k < N; k++)
      strong_vec[k] = (cls_q[k] == CLS_STRONG);
  end

  assign nbr_hit = |(NBR_MASK[idx] & strong_vec);

  always_comb begin
    elem_val = '0;
    unique case (cls_q[idx])
      CLS_STRONG: elem_val = EDGE_VAL;
      CLS_WEAK:   elem_val = nbr_hit ? EDGE_VAL : '0;
      default:    elem_val = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (bus.Enable) state_n = CLASSIFY;
      CLASSIFY:
        if (!bus.Enable) state_n = IDLE;
        else if (last)   state_n = HYST;
      HYST:
        if (!bus.Enable) state_n = IDLE;
        else if (last)   state_n = DONE;
      DONE:
        if (!bus.Enable) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      done_q <= 1'b0;
      img_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      for (int k = 0; k < N; k++) begin
        cls_q[k] <= CLS_NONE;
        gm_q[k]  <= '0;
      end
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.Enable) begin
            idx  <= '0;
            hi_q <= bus.high_thr;
            lo_q <= bus.low_thr;
            for (int k = 0; k < N; k++)
              gm_q[k] <= bus.GM_T[k*DATA_W +: DATA_W];
          end
        end
        CLASSIFY: begin
          if (!bus.Enable) begin
            img_q <= '0;
            idx   <= '0;
          end else begin
            cls_q[idx] <= cls_cur;
            idx        <= last ? '0 : idx + 1'b1;
          end
        end
        HYST: begin
          if (!bus.Enable) begin
            img_q <= '0;
            idx   <= '0;
          end else begin
            img_q[idx*DATA_W +: DATA_W] <= elem_val;
            idx <= last ? '0 : idx + 1'b1;
          end
        end
        DONE:
          done_q <= bus.Enable;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gm_double_threshold.sv
// Directed bench for gm_double_threshold with a window-level model
// and a per-cycle compare of done/img_result.
module tb_gm_double_threshold;
  import gm_pkg::*;

  typedef logic [N*DATA_W-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  bit   chk_on = 1'b0;

  always #5 clk = ~clk;

  gm_double_threshold_if bus ();

  gm_double_threshold dut (
    .Clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  function automatic vec_t pk(input int e[9]);
    vec_t r = '0;
    for (int k = 0; k < 9; k++)
      r[k*DATA_W +: DATA_W] = e[k][DATA_W-1:0];
    return r;
  endfunction

  // expected edge window straight from the threshold/hysteresis rules
  function automatic vec_t exp_win(input vec_t gm,
                                   input logic [DATA_W-1:0] hi,
                                   input logic [DATA_W-1:0] lo);
    vec_t r = '0;
    logic [DATA_W-1:0] g [3][3];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        g[i][j] = gm[(i*3+j)*DATA_W +: DATA_W];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        bit e = 0;
        if (g[i][j] >= hi) e = 1;
        else if (g[i][j] >= lo) begin
          for (int di = -1; di <= 1; di++)
            for (int dj = -1; dj <= 1; dj++)
              if ((di != 0 || dj != 0) &&
                  i+di >= 0 && i+di < 3 &&
                  j+dj >= 0 && j+dj < 3 &&
                  g[i+di][j+dj] >= hi)
                e = 1;
        end
        if (e) r[(i*3+j)*DATA_W +: DATA_W] = 255;
      end
    return r;
  endfunction

  task automatic chk(input string nm, input vec_t got, input vec_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // cycle model: start edge, 18 busy edges, done on the next edge
  int   m_phase = 0;
  int   m_cnt = 0;
  logic m_done = 1'b0;
  logic m_valid = 1'b1;
  vec_t m_img = '0;
  vec_t m_exp = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_done  <= 1'b0;
      m_img   <= '0;
      m_valid <= 1'b1;
    end else begin
      case (m_phase)
        0: if (bus.Enable) begin
          m_exp   <= exp_win(bus.GM_T, bus.high_thr, bus.low_thr);
          m_cnt   <= 0;
          m_phase <= 1;
          m_valid <= 1'b0;
        end
        1: if (!bus.Enable) begin
          m_phase <= 0;
          m_img   <= '0;
          m_valid <= 1'b1;
        end else begin
          if (m_cnt == 17) m_phase <= 2;
          m_cnt <= m_cnt + 1;
        end
        default: if (bus.Enable) begin
          m_done  <= 1'b1;
          m_img   <= m_exp;
          m_valid <= 1'b1;
        end else begin
          m_done  <= 1'b0;
          m_phase <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      total++;
      if (bus.done !== m_done) begin
        bad++;
        $display("FAIL cyc_done got=%b exp=%b t=%0t",
                 bus.done, m_done, $time);
      end
      if (m_valid) begin
        total++;
        if (bus.img_result !== m_img) begin
          bad++;
          $display("FAIL cyc_img got=%h exp=%h t=%0t",
                   bus.img_result, m_img, $time);
        end
      end
    end
  end

  task automatic start(input vec_t gm, input int hi, input int lo);
    bus.GM_T     = gm;
    bus.high_thr = hi[DATA_W-1:0];
    bus.low_thr  = lo[DATA_W-1:0];
    bus.Enable   = 1'b1;
  endtask

  task automatic run_window(input string nm, input vec_t gm,
                            input int hi, input int lo, input vec_t exp);
    int  lat = -1;
    bit  seen = 0;
    chk({nm, "_model"}, exp_win(gm, hi[DATA_W-1:0], lo[DATA_W-1:0]), exp);
    start(gm, hi, lo);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        seen = 1;
        lat  = i;
        break;
      end
    end
    total++;
    if (!seen || lat != 19) begin
      bad++;
      $display("FAIL %s_latency got=%0d exp=19", nm, lat);
    end
    chk({nm, "_img"}, bus.img_result, exp);
    bus.GM_T     = '1;
    bus.high_thr = '0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk({nm, "_hold_done"}, vec_t'(bus.done), vec_t'(1));
    chk({nm, "_hold_img"}, bus.img_result, exp);
    bus.Enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_done_fall"}, vec_t'(bus.done), vec_t'(0));
  endtask

  vec_t g2, g3;

  initial begin
    bus.Enable   = 1'b0;
    bus.GM_T     = '0;
    bus.high_thr = '0;
    bus.low_thr  = '0;
    g2 = pk('{250, 0, 0, 0, 150, 0, 0, 0, 0});
    g3 = pk('{250, 0, 0, 0, 0, 0, 0, 0, 150});
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_done", vec_t'(bus.done), vec_t'(0));
    chk("rst_img", bus.img_result, '0);
    rst = 1'b0;
    chk_on = 1'b1;

    run_window("zero", '0, 200, 100, '0);
    run_window("c2", g2, 200, 100,
               pk('{255, 0, 0, 0, 255, 0, 0, 0, 0}));
    run_window("c3", g3, 200, 100,
               pk('{255, 0, 0, 0, 0, 0, 0, 0, 0}));
    run_window("c4a", pk('{200, 100, 99, 199, 0, 0, 0, 0, 0}), 200, 100,
               pk('{255, 255, 0, 255, 0, 0, 0, 0, 0}));
    run_window("c4b", pk('{200, 100, 99, 199, 0, 0, 0, 0, 0}), 120, 150,
               pk('{255, 0, 0, 255, 0, 0, 0, 0, 0}));

    // reset while classifying element 4
    start(g2, 200, 100);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("c5_done", vec_t'(bus.done), vec_t'(0));
    chk("c5_img", bus.img_result, '0);
    rst = 1'b0;
    bus.Enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    run_window("c5_rerun", g2, 200, 100,
               pk('{255, 0, 0, 0, 255, 0, 0, 0, 0}));

    // Enable dropped while hysteresis sits on element 3
    start(g2, 200, 100);
    repeat (13) @(posedge clk);
    @(negedge clk);
    bus.Enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("c6_abort_img", bus.img_result, '0);
    chk("c6_abort_done", vec_t'(bus.done), vec_t'(0));
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("c6_no_done", vec_t'(bus.done), vec_t'(0));

    run_window("b2b_a", g2, 200, 100,
               pk('{255, 0, 0, 0, 255, 0, 0, 0, 0}));
    run_window("b2b_b", g3, 200, 100,
               pk('{255, 0, 0, 0, 0, 0, 0, 0, 0}));

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
